// File: rtl/rv32im_alu_control.sv
// ALU control decoder for the RV32IM ID/EX boundary: maps alu_op/funct3/funct7
// to a 4-bit ALU code, an M-extension select and an illegal-encoding flag, registered.
module rv32im_alu_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_control,
    output logic       mdu_en,
    output logic [2:0] mdu_op,
    output logic       illegal
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [1:0] OP_MEM    = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_RTYPE  = 2'b10;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MDU  = 7'b0000001;

    logic [3:0] alu_control_d, alu_control_q;
    logic       mdu_en_d, mdu_en_q;
    logic [2:0] mdu_op_d, mdu_op_q;
    logic       illegal_d, illegal_q;

    // funct3 -> ALU code for the base (funct7=0) encodings shared by R and I types
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        logic [3:0] code;
        case (f3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    always_comb begin
        alu_control_d = ALU_ADD;
        mdu_en_d      = 1'b0;
        mdu_op_d      = 3'b000;
        illegal_d     = 1'b0;
        case (alu_op)
            OP_MEM: begin
                alu_control_d = ALU_ADD;
            end
            OP_BRANCH: begin
                alu_control_d = ALU_SUB;
            end
            OP_RTYPE: begin
                case (funct7)
                    F7_BASE: alu_control_d = base_op(funct3);
                    F7_ALT: begin
                        case (funct3)
                            3'b000:  alu_control_d = ALU_SUB;
                            3'b101:  alu_control_d = ALU_SRA;
                            default: illegal_d     = 1'b1;
                        endcase
                    end
                    F7_MDU: begin
                        mdu_en_d = 1'b1;
                        mdu_op_d = funct3;
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            default: begin
                // I-type: funct7 only matters for the shift-immediate encodings
                case (funct3)
                    3'b001: begin
                        if (funct7 == F7_BASE) alu_control_d = ALU_SLL;
                        else                   illegal_d     = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE)     alu_control_d = ALU_SRL;
                        else if (funct7 == F7_ALT) alu_control_d = ALU_SRA;
                        else                       illegal_d     = 1'b1;
                    end
                    default: alu_control_d = base_op(funct3);
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_control_q <= ALU_ADD;
            mdu_en_q      <= 1'b0;
            mdu_op_q      <= 3'b000;
            illegal_q     <= 1'b0;
        end else if (en) begin
            alu_control_q <= alu_control_d;
            mdu_en_q      <= mdu_en_d;
            mdu_op_q      <= mdu_op_d;
            illegal_q     <= illegal_d;
        end
    end

    assign alu_control = alu_control_q;
    assign mdu_en      = mdu_en_q;
    assign mdu_op      = mdu_op_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_rv32im_alu_control.sv
// Scoreboard bench for rv32im_alu_control: driver pushes expected registered outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_rv32im_alu_control;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] alu_control;
    logic       mdu_en;
    logic [2:0] mdu_op;
    logic       illegal;

    typedef struct packed {
        logic [3:0] ctl;
        logic       men;
        logic [2:0] mop;
        logic       ill;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    exp_t  model_state;
    int    tests;
    int    fails;
    bit    driver_done;

    // ALU codes of ADD SLL SLT SLTU XOR SRL OR AND, indexed by funct3
    int base_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    rv32im_alu_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7     (funct7),
        .alu_control(alu_control),
        .mdu_en     (mdu_en),
        .mdu_op     (mdu_op),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t decode(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
        exp_t r;
        int   code;
        r = '0;
        code = 0;
        if (op == 2'd1) begin
            code = 1;
        end else if (op == 2'd2) begin
            if (f7 == 7'd0) code = base_tab[f3];
            else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) code = base_tab[f3] + 1;
            else if (f7 == 7'd1) begin r.men = 1'b1; r.mop = f3; end
            else r.ill = 1'b1;
        end else if (op == 2'd3) begin
            if (f3 == 3'd1) begin
                if (f7 == 7'd0) code = 2; else r.ill = 1'b1;
            end else if (f3 == 3'd5) begin
                if (f7 == 7'd0) code = 6;
                else if (f7 == 7'h20) code = 7;
                else r.ill = 1'b1;
            end else begin
                code = base_tab[f3];
            end
        end
        r.ctl = 4'(code);
        return r;
    endfunction

    function automatic exp_t next_state(input logic rs, input logic e, input logic [1:0] op,
                                        input logic [2:0] f3, input logic [6:0] f7);
        if (!rs) return '0;
        if (e)   return decode(op, f3, f7);
        return model_state;
    endfunction

    task automatic step(input string tag, input logic rs, input logic e,
                        input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
        rst_n = rs; en = e; alu_op = op; funct3 = f3; funct7 = f7;
        model_state = next_state(rs, e, op, f3, f7);
        exp_q.push_back(model_state);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // first inputs are applied, then replaced after the negedge; only the second set is loaded
    task automatic step_mid(input string tag, input logic [1:0] op1, input logic [2:0] f31,
                            input logic [6:0] f71, input logic [1:0] op2, input logic [2:0] f32,
                            input logic [6:0] f72);
        rst_n = 1'b1; en = 1'b1; alu_op = op1; funct3 = f31; funct7 = f71;
        @(negedge clk);
        #1;
        alu_op = op2; funct3 = f32; funct7 = f72;
        model_state = next_state(1'b1, 1'b1, op2, f32, f72);
        exp_q.push_back(model_state);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            tests++;
            if (alu_control !== e.ctl || mdu_en !== e.men || mdu_op !== e.mop || illegal !== e.ill) begin
                fails++;
                $display("FAIL %s: got ctl=%b mdu_en=%b mdu_op=%b illegal=%b, expected ctl=%b mdu_en=%b mdu_op=%b illegal=%b",
                         t, alu_control, mdu_en, mdu_op, illegal, e.ctl, e.men, e.mop, e.ill);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        driver_done = 1'b0;
        model_state = '0;

        step("reset0", 1'b0, 1'b1, 2'b10, 3'b111, 7'd0);
        step("reset1", 1'b0, 1'b1, 2'b10, 3'b111, 7'd0);
        step("post_reset_and", 1'b1, 1'b1, 2'b10, 3'b111, 7'd0);

        step("r_add",   1'b1, 1'b1, 2'b10, 3'b000, 7'h00);
        step("r_sub",   1'b1, 1'b1, 2'b10, 3'b000, 7'h20);
        step("r_and",   1'b1, 1'b1, 2'b10, 3'b111, 7'h00);
        step("r_sra",   1'b1, 1'b1, 2'b10, 3'b101, 7'h20);
        step("r_ill",   1'b1, 1'b1, 2'b10, 3'b010, 7'h20);
        step("r_ill_f7",1'b1, 1'b1, 2'b10, 3'b000, 7'h7f);

        step("i_add",   1'b1, 1'b1, 2'b11, 3'b000, 7'h00);
        step("i_and",   1'b1, 1'b1, 2'b11, 3'b111, 7'h00);
        step("i_add_f7",1'b1, 1'b1, 2'b11, 3'b000, 7'h20);
        step("i_srai",  1'b1, 1'b1, 2'b11, 3'b101, 7'h20);
        step("i_slli_ill", 1'b1, 1'b1, 2'b11, 3'b001, 7'h20);
        step("i_srli",  1'b1, 1'b1, 2'b11, 3'b101, 7'h00);

        step("branch",  1'b1, 1'b1, 2'b01, 3'b111, 7'h55);
        step("mem",     1'b1, 1'b1, 2'b00, 3'b111, 7'h55);

        for (int i = 0; i < 8; i++) step("mdu_sweep", 1'b1, 1'b1, 2'b10, 3'(i), 7'h01);
        step("i_f7_mdu", 1'b1, 1'b1, 2'b11, 3'b000, 7'h01);

        step("stall_load", 1'b1, 1'b1, 2'b10, 3'b000, 7'h20);
        for (int i = 0; i < 3; i++) step("stall_hold", 1'b1, 1'b0, 2'b10, 3'b111, 7'h00);
        step("stall_release", 1'b1, 1'b1, 2'b10, 3'b111, 7'h00);
        step_mid("mid_change", 2'b10, 3'b000, 7'h20, 2'b10, 3'b100, 7'h00);
        step("reset_over_stall", 1'b0, 1'b0, 2'b10, 3'b111, 7'h00);

        for (int i = 0; i < 400; i++) begin
            logic [6:0] f7r;
            case ($urandom_range(0, 3))
                0:       f7r = 7'h00;
                1:       f7r = 7'h20;
                2:       f7r = 7'h01;
                default: f7r = 7'($urandom);
            endcase
            step("random", ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                 2'($urandom), 3'($urandom), f7r);
        end

        en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv32im_alu_control.md
Name:
rv32im_alu_control

Overview:
- Decodes the main-decoder `alu_op` class plus instruction `funct3`/`funct7` into a 4-bit ALU operation code.
- Also produces a multiply/divide (M-extension) select and an illegal-encoding flag.
- Sits in the ID/EX boundary of the RV32IM pipeline.
- Outputs are registered: they present the decode of the inputs sampled at the previous rising clock edge.

Parameters:
- None.

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low
- en  input  1  pipeline advance; 0 = hold all outputs (stall)
- alu_op  input  2  instruction class: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU
- funct3  input  3  instruction bits [14:12]
- funct7  input  7  instruction bits [31:25]
- alu_control  output  4  ALU operation code (registered)
- mdu_en  output  1  1 = operation goes to the mul/div unit (registered)
- mdu_op  output  3  mul/div operation = funct3 when mdu_en=1, else 000 (registered)
- illegal  output  1  unsupported funct3/funct7 combination (registered)

Behaviour:
- ALU codes:
  - ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100
  - XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001
  - 1010-1111 reserved, never driven.
- Reset: on a rising clk edge with rst_n=0, outputs become alu_control=0000, mdu_en=0, mdu_op=000, illegal=0. Reset has priority over en.
- Stall: rising edge with rst_n=1 and en=0 leaves all outputs unchanged.
- Update: rising edge with rst_n=1 and en=1 loads the combinational decode below. Latency is exactly 1 cycle.
- alu_op=00 (load/store): ADD. funct3/funct7 ignored, illegal=0.
- alu_op=01 (branch): SUB for every funct3. funct7 ignored, illegal=0.
- alu_op=10 (R-type), decode by funct7:
  - funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: funct3 000 SUB, 101 SRA. Any other funct3 is illegal.
  - funct7=0000001: mdu_en=1, mdu_op=funct3 (MUL..REMU), alu_control=ADD.
  - Any other funct7: illegal.
- alu_op=11 (I-type):
  - funct7 is ignored except for shifts: funct3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - funct3=001 (SLLI): SLL, legal only when funct7=0000000.
  - funct3=101: funct7=0000000 gives SRL, funct7=0100000 gives SRA. Any other funct7 is illegal.
- Illegal case: illegal=1, alu_control=ADD, mdu_en=0, mdu_op=000.
- mdu_en=1 only when alu_op=10 and funct7=0000001.
- Inputs are fully decoded; no X propagation for any 12-bit input combination.

Test Plan:
- Reset: rst_n=0 for 2 edges with alu_op=10, funct3=111 -> alu_control=0000, mdu_en=0, mdu_op=000, illegal=0. Then release rst_n=1 with en=1 -> next edge gives AND (1001).
- R-type, alu_op=10, one edge apart:
  - funct3=000, funct7=0000000 -> 0000.
  - funct7=0100000 -> 0001.
  - funct3=111, funct7=0000000 -> 1001.
  - funct3=101, funct7=0100000 -> 0111.
  - funct3=010, funct7=0100000 -> illegal=1, alu_control=0000.
- I-type, alu_op=11:
  - funct3=000, funct7=0000000 -> 0000.
  - funct3=111 -> 1001.
  - funct3=000, funct7=0100000 -> 0000, illegal=0.
  - funct3=101, funct7=0100000 -> 0111.
  - funct3=001, funct7=0100000 -> illegal=1.
- Branch/memory:
  - alu_op=01, funct3=111 -> 0001.
  - alu_op=00, funct3=111 -> 0000.
  - Both with illegal=0.
- M-extension: alu_op=10, funct7=0000001, sweep funct3 000..111 -> mdu_en=1, mdu_op=funct3, alu_control=0000, illegal=0. The same funct7 with alu_op=11, funct3=000 -> mdu_en=0.
- Stall and latency:
  - Load SUB (alu_op=10, funct3=000, funct7=0100000), then en=0 and change inputs to AND for 3 edges -> output stays 0001.
  - Set en=1 -> 1001 one edge later.
  - Change inputs mid-cycle -> outputs do not change before the next rising edge.
